// File: rtl/mem_dados_bytes.sv
// Byte-addressable 32-bit data memory, big-endian lanes, 1-cycle load latency.
// Define MEM_DADOS_ALIGN_CHECK_EN to drop and flag misaligned half/word requests.
module mem_dados_bytes #(
    parameter int ADDR_W     = 7,
    parameter int INIT_CLEAR = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              ONescrita,
    input  logic [1:0]        tamanho,
    input  logic              sinal,
    input  logic [ADDR_W+1:0] endereco,
    input  logic [31:0]       dadoEscrita,
    output logic              pronto,
    output logic [31:0]       dadoLeitura,
    output logic              leituraValida,
    output logic              erroAlinhamento
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {LIMPA, OCIOSO} estado_t;

    localparam estado_t EST_RST = (INIT_CLEAR != 0) ? LIMPA : OCIOSO;

    estado_t           estado_q, estado_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [31:0]       mem_q [DEPTH];
    logic [31:0]       dl_q, dl_d;
    logic              lv_q, lv_d;
    logic              err_q, err_d;

    logic [ADDR_W-1:0] idx;
    logic [1:0]        off;
    logic [31:0]       rw;
    logic [31:0]       byte_sh;
    logic [31:0]       half_sh;
    logic [31:0]       rd;
    logic [3:0]        be;
    logic [31:0]       wlane;
    logic [31:0]       wmerge;
    logic              desal;
    logic              acc;
    logic              st;
    logic              ld;

    assign idx     = endereco[ADDR_W+1:2];
    assign off     = endereco[1:0];
    assign rw      = mem_q[idx];
    assign pronto  = (estado_q == OCIOSO) && !reset;
    assign acc     = req && pronto;
    assign st      = acc && ONescrita && !desal;
    assign ld      = acc && !ONescrita && !desal;

`ifdef MEM_DADOS_ALIGN_CHECK_EN
    assign desal = ((tamanho == 2'b01) && endereco[0]) ||
                   (tamanho[1] && (endereco[1:0] != 2'b00));
`else
    assign desal = 1'b0;
`endif

    // ~off is (3 - off): offset 0 lives in the top byte
    assign byte_sh = rw >> {~off, 3'b000};
    assign half_sh = rw >> {~endereco[1], 4'b0000};

    always_comb begin
        rd    = rw;
        be    = 4'b1111;
        wlane = dadoEscrita;
        unique case (tamanho)
            2'b00: begin
                rd    = {{24{sinal & byte_sh[7]}}, byte_sh[7:0]};
                be    = 4'b1000 >> off;
                wlane = {4{dadoEscrita[7:0]}};
            end
            2'b01: begin
                rd    = {{16{sinal & half_sh[15]}}, half_sh[15:0]};
                be    = endereco[1] ? 4'b0011 : 4'b1100;
                wlane = {2{dadoEscrita[15:0]}};
            end
            default: begin
                rd    = rw;
                be    = 4'b1111;
                wlane = dadoEscrita;
            end
        endcase
    end

    always_comb begin
        wmerge = rw;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) wmerge[8*i +: 8] = wlane[8*i +: 8];
        end
    end

    always_comb begin
        estado_d = estado_q;
        cnt_d    = cnt_q;
        dl_d     = dl_q;
        lv_d     = 1'b0;
        err_d    = acc && desal;
        if (estado_q == LIMPA) begin
            cnt_d = cnt_q + 1'b1;
            if (&cnt_q) estado_d = OCIOSO;
        end
        if (ld) begin
            dl_d = rd;
            lv_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q <= EST_RST;
            cnt_q    <= '0;
            dl_q     <= '0;
            lv_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            estado_q <= estado_d;
            cnt_q    <= cnt_d;
            dl_q     <= dl_d;
            lv_q     <= lv_d;
            err_q    <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            if (estado_q == LIMPA) mem_q[cnt_q] <= '0;
            else if (st)           mem_q[idx]   <= wmerge;
        end
    end

    assign dadoLeitura     = dl_q;
    assign leituraValida   = lv_q;
    assign erroAlinhamento = err_q;

endmodule

// File: tb/tb_mem_dados_bytes.sv
// Scoreboard bench for mem_dados_bytes: directed loads/stores, clear timing,
// reset during clear.
module tb_mem_dados_bytes;

    localparam int AW = 7;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req = 1'b0;
    logic          ONescrita = 1'b0;
    logic [1:0]    tamanho = 2'b10;
    logic          sinal = 1'b0;
    logic [AW+1:0] endereco = '0;
    logic [31:0]   dadoEscrita = '0;
    logic          pronto;
    logic [31:0]   dadoLeitura;
    logic          leituraValida;
    logic          erroAlinhamento;

    int checks = 0;
    int errors = 0;
    int err_pulses = 0;
    logic [31:0] exp_q [$];
    logic [31:0] last_exp = '0;

    mem_dados_bytes #(.ADDR_W(AW), .INIT_CLEAR(1)) dut (
        .clk(clk), .reset(reset), .req(req), .ONescrita(ONescrita),
        .tamanho(tamanho), .sinal(sinal), .endereco(endereco),
        .dadoEscrita(dadoEscrita), .pronto(pronto),
        .dadoLeitura(dadoLeitura), .leituraValida(leituraValida),
        .erroAlinhamento(erroAlinhamento)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (erroAlinhamento === 1'b1) err_pulses++;
        if (leituraValida === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", 32'd1, 32'd0);
            end else begin
                chk("load_data", dadoLeitura, exp_q.pop_front());
            end
        end
    end

    task automatic op(input logic we, input logic [1:0] sz, input logic sg,
                      input logic [AW+1:0] a, input logic [31:0] wd,
                      input logic [31:0] ex);
        @(negedge clk);
        req = 1'b1; ONescrita = we; tamanho = sz; sinal = sg;
        endereco = a; dadoEscrita = wd;
        if (!we) begin
            exp_q.push_back(ex);
            last_exp = ex;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            req = 1'b0;
        end
    endtask

    task automatic wait_pronto(input string nm);
        int n;
        n = 0;
        while (!pronto && n < 400) begin
            n++;
            @(negedge clk);
        end
        chk(nm, 32'(n), 32'd128);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_pronto", {31'd0, pronto}, 32'd0);
        chk("rst_valid", {31'd0, leituraValida}, 32'd0);
        chk("rst_dado", dadoLeitura, 32'd0);
        chk("rst_err", {31'd0, erroAlinhamento}, 32'd0);
        reset = 1'b0;
        wait_pronto("clear_cycles");

        op(0, 2'b10, 0, 9'h000, 0, 32'h0000_0000);
        op(0, 2'b10, 0, 9'h1FC, 0, 32'h0000_0000);
        op(0, 2'b10, 0, 9'h040, 0, 32'h0000_0000);

        op(1, 2'b10, 0, 9'h010, 32'h1122_3344, 0);
        op(1, 2'b00, 0, 9'h012, 32'h0000_00AA, 0);
        op(0, 2'b10, 0, 9'h010, 0, 32'h1122_AA44);
        idle(2);

        op(1, 2'b10, 0, 9'h020, 32'h80FF_7F01, 0);
        op(0, 2'b00, 1, 9'h020, 0, 32'hFFFF_FF80);
        op(0, 2'b01, 0, 9'h022, 0, 32'h0000_7F01);
        op(0, 2'b01, 1, 9'h022, 0, 32'h0000_7F01);
        op(0, 2'b00, 1, 9'h021, 0, 32'hFFFF_FFFF);
        op(0, 2'b00, 0, 9'h021, 0, 32'h0000_00FF);
        op(0, 2'b00, 0, 9'h023, 0, 32'h0000_0001);
        op(0, 2'b01, 1, 9'h020, 0, 32'hFFFF_80FF);
        op(0, 2'b11, 1, 9'h020, 0, 32'h80FF_7F01);

        op(1, 2'b10, 0, 9'h004, 32'hCAFE_F00D, 0);
        op(0, 2'b10, 0, 9'h004, 0, 32'hCAFE_F00D);
        op(0, 2'b10, 0, 9'h010, 0, 32'h1122_AA44);
        op(0, 2'b10, 0, 9'h004, 0, 32'hCAFE_F00D);
        op(1, 2'b01, 0, 9'h006, 32'h0000_1234, 0);
        op(0, 2'b10, 0, 9'h004, 0, 32'hCAFE_1234);
        op(1, 2'b10, 0, 9'h005, 32'h5566_7788, 0);
`ifdef MEM_DADOS_ALIGN_CHECK_EN
        op(0, 2'b10, 0, 9'h004, 0, 32'hCAFE_1234);
`else
        op(0, 2'b10, 0, 9'h004, 0, 32'h5566_7788);
`endif
        op(1, 2'b10, 0, 9'h1FC, 32'hA5A5_A5A5, 0);
        op(0, 2'b10, 0, 9'h1FC, 0, 32'hA5A5_A5A5);
        op(0, 2'b10, 0, 9'h000, 0, 32'h0000_0000);
        op(0, 2'b00, 1, 9'h1FF, 0, 32'hFFFF_FFA5);
        idle(4);
        chk("hold_dado", dadoLeitura, last_exp);
        chk("hold_valid", {31'd0, leituraValida}, 32'd0);
`ifdef MEM_DADOS_ALIGN_CHECK_EN
        chk("err_pulses", 32'(err_pulses), 32'd1);
`else
        chk("err_pulses", 32'(err_pulses), 32'd0);
`endif

        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (50) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst2_pronto", {31'd0, pronto}, 32'd0);
        reset = 1'b0;
        req = 1'b1; ONescrita = 1'b1; tamanho = 2'b10;
        endereco = 9'h000; dadoEscrita = 32'hDEAD_BEEF;
        begin
            int n;
            n = 0;
            while (!pronto && n < 400) begin
                n++;
                @(negedge clk);
            end
            req = 1'b0;
            chk("reclear_cycles", 32'(n), 32'd128);
        end
        op(0, 2'b10, 0, 9'h000, 0, 32'h0000_0000);
        op(0, 2'b10, 0, 9'h010, 0, 32'h0000_0000);
        op(0, 2'b10, 0, 9'h1FC, 0, 32'h0000_0000);
        idle(4);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got 1 want 0");
        $fatal(1, "timeout");
    end

endmodule
